// File: rtl/lampfpu_sqrt_ctrl.sv
// LAMP float square-root controller: resolves special operands locally, hands normal
// significands to the sqrt core and repacks the result. The LAMP_SQRT_TIMEOUT_EN macro adds a WAIT-state watchdog.
module lampfpu_sqrt_ctrl
`ifdef LAMP_SQRT_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] op_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [15:0] res_o,
    output logic        invalid_o,
    output logic        do_sqrt_o,
    output logic [7:0]  s_o,
    output logic        is_exp_odd_o,
    input  logic        core_valid_i,
    input  logic [7:0]  core_res_i
`ifdef LAMP_SQRT_TIMEOUT_EN
    ,
    output logic        timeout_o
`endif
);

    localparam logic [15:0] QNAN    = 16'h7FC0;
    localparam logic [15:0] POS_INF = 16'h7F80;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t state;
    logic [7:0] exp_q;

    logic       op_sign;
    logic [7:0] op_exp;
    logic [6:0] op_frac;
    logic       special;
    logic [15:0] special_res;
    logic       special_inv;
    logic [7:0] res_exp;

    assign op_sign = op_i[15];
    assign op_exp  = op_i[14:7];
    assign op_frac = op_i[6:0];

    // Biased result exponent; the 9-bit sum absorbs the carry before halving.
    assign res_exp = 8'((9'(exp_q) + 9'd127) >> 1);

    // Operand classification for the accept cycle; priority matters for -inf.
    always_comb begin
        special     = 1'b1;
        special_res = QNAN;
        special_inv = 1'b0;
        if (op_exp == 8'hFF && op_frac != 7'd0) begin
            special_res = QNAN;
        end else if (op_exp == 8'hFF && !op_sign) begin
            special_res = POS_INF;
        end else if (op_exp == 8'h00) begin
            special_res = {op_sign, 15'd0};
        end else if (op_sign) begin
            special_res = QNAN;
            special_inv = 1'b1;
        end else begin
            special = 1'b0;
        end
    end

`ifdef LAMP_SQRT_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            exp_q        <= 8'd0;
            busy_o       <= 1'b0;
            valid_o      <= 1'b0;
            res_o        <= 16'd0;
            invalid_o    <= 1'b0;
            do_sqrt_o    <= 1'b0;
            s_o          <= 8'd0;
            is_exp_odd_o <= 1'b0;
`ifdef LAMP_SQRT_TIMEOUT_EN
            wait_cnt     <= '0;
            timeout_o    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        exp_q  <= op_exp;
                        if (special) begin
                            res_o     <= special_res;
                            invalid_o <= special_inv;
                            valid_o   <= 1'b1;
                            state     <= DONE;
                        end else begin
                            do_sqrt_o    <= 1'b1;
                            s_o          <= {1'b1, op_frac};
                            is_exp_odd_o <= ~op_exp[0];
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    do_sqrt_o <= 1'b0;
                    state     <= WAIT;
`ifdef LAMP_SQRT_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                end
                WAIT: begin
                    if (core_valid_i) begin
                        // A cleared hidden bit means the core's rounding wrapped to 2.0.
                        if (core_res_i[7]) begin
                            res_o <= {1'b0, res_exp, core_res_i[6:0]};
                        end else begin
                            res_o <= {1'b0, res_exp + 8'd1, 7'd0};
                        end
                        invalid_o <= 1'b0;
                        valid_o   <= 1'b1;
                        state     <= DONE;
                    end
`ifdef LAMP_SQRT_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        res_o     <= QNAN;
                        invalid_o <= 1'b1;
                        valid_o   <= 1'b1;
                        timeout_o <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                DONE: begin
                    valid_o   <= 1'b0;
                    invalid_o <= 1'b0;
                    busy_o    <= 1'b0;
`ifdef LAMP_SQRT_TIMEOUT_EN
                    timeout_o <= 1'b0;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lampfpu_sqrt_ctrl.sv
// Directed bench for lampfpu_sqrt_ctrl; the bench plays the sqrt core.
// Define LAMP_SQRT_TIMEOUT_EN to also exercise the watchdog.
module tb_lampfpu_sqrt_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [15:0] op_i;
    logic        busy_o;
    logic        valid_o;
    logic [15:0] res_o;
    logic        invalid_o;
    logic        do_sqrt_o;
    logic [7:0]  s_o;
    logic        is_exp_odd_o;
    logic        core_valid_i;
    logic [7:0]  core_res_i;
`ifdef LAMP_SQRT_TIMEOUT_EN
    logic        timeout_o;
`endif

    int checks   = 0;
    int failures = 0;

    lampfpu_sqrt_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .op_i         (op_i),
        .busy_o       (busy_o),
        .valid_o      (valid_o),
        .res_o        (res_o),
        .invalid_o    (invalid_o),
        .do_sqrt_o    (do_sqrt_o),
        .s_o          (s_o),
        .is_exp_odd_o (is_exp_odd_o),
        .core_valid_i (core_valid_i),
        .core_res_i   (core_res_i)
`ifdef LAMP_SQRT_TIMEOUT_EN
        ,
        .timeout_o    (timeout_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; op_i = 16'h0; core_valid_i = 1'b0; core_res_i = 8'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_o, valid_o, invalid_o, do_sqrt_o, is_exp_odd_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy_o, valid_o, invalid_o, do_sqrt_o, is_exp_odd_o});
        end
        checks++;
        if ({res_o, s_o} !== 24'h0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 000000", {res_o, s_o});
        end
        rst = 1'b0;
        // Core valid in IDLE must be ignored.
        core_valid_i = 1'b1; core_res_i = 8'hFF;
        @(negedge clk);
        core_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid_o, busy_o} !== 2'b00) begin
            failures++;
            $display("FAIL idle_core_valid: got %b expected 00", {valid_o, busy_o});
        end
    endtask

    task automatic test_normal(input logic [15:0] op, input logic [7:0] exp_s, input logic exp_odd,
                               input logic [7:0] core_ans, input logic [15:0] exp_res);
        @(negedge clk); start_i = 1'b1; op_i = op;
        @(negedge clk); start_i = 1'b0;
        checks++;
        if ({do_sqrt_o, busy_o, valid_o} !== 3'b110) begin
            failures++;
            $display("FAIL issue_flags op=%h: got %b expected 110", op, {do_sqrt_o, busy_o, valid_o});
        end
        checks++;
        if ({s_o, is_exp_odd_o} !== {exp_s, exp_odd}) begin
            failures++;
            $display("FAIL issue_data op=%h: got %h/%b expected %h/%b", op, s_o, is_exp_odd_o, exp_s, exp_odd);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({do_sqrt_o, valid_o, busy_o, s_o, is_exp_odd_o} !== {3'b001, exp_s, exp_odd}) begin
            failures++;
            $display("FAIL wait_hold op=%h: got %b/%h expected 001/%h", op,
                     {do_sqrt_o, valid_o, busy_o}, s_o, exp_s);
        end
        core_valid_i = 1'b1; core_res_i = core_ans;
        @(negedge clk); core_valid_i = 1'b0;
        checks++;
        if ({valid_o, busy_o, invalid_o, res_o} !== {3'b110, exp_res}) begin
            failures++;
            $display("FAIL done op=%h: got %b/%h expected 110/%h", op, {valid_o, busy_o, invalid_o}, res_o, exp_res);
        end
        @(negedge clk);
        checks++;
        if ({valid_o, busy_o, res_o} !== {2'b00, exp_res}) begin
            failures++;
            $display("FAIL after_done op=%h: got %b/%h expected 00/%h", op, {valid_o, busy_o}, res_o, exp_res);
        end
    endtask

    task automatic test_specials();
        logic [15:0] ops  [6] = '{16'hC080, 16'h8000, 16'h7F80, 16'h0001, 16'h7FC1, 16'hFF80};
        logic [15:0] ress [6] = '{16'h7FC0, 16'h8000, 16'h7F80, 16'h0000, 16'h7FC0, 16'h7FC0};
        logic        invs [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); start_i = 1'b1; op_i = ops[i];
            @(negedge clk);
            // Keep start high through DONE with a fresh operand: it must be dropped.
            op_i = 16'h4080;
            checks++;
            if ({valid_o, busy_o, do_sqrt_o, invalid_o, res_o} !== {3'b110, invs[i], ress[i]}) begin
                failures++;
                $display("FAIL special op=%h: got %b%b/%h expected 110%b/%h", ops[i],
                         {valid_o, busy_o, do_sqrt_o}, invalid_o, res_o, invs[i], ress[i]);
            end
            @(negedge clk); start_i = 1'b0;
            checks++;
            if ({valid_o, busy_o, do_sqrt_o} !== 3'b000) begin
                failures++;
                $display("FAIL done_start_ignored op=%h: got %b expected 000", ops[i], {valid_o, busy_o, do_sqrt_o});
            end
        end
    endtask

    task automatic test_wrap_and_ignored_start();
        int vcount = 0;
        int dcount = 0;
        @(negedge clk); start_i = 1'b1; op_i = 16'h4080;
        @(negedge clk); start_i = 1'b0; if (do_sqrt_o) dcount++;
        @(negedge clk); start_i = 1'b1; op_i = 16'h0000; if (do_sqrt_o) dcount++;
        @(negedge clk); op_i = 16'hC080; if (valid_o) vcount++; if (do_sqrt_o) dcount++;
        @(negedge clk); start_i = 1'b0; if (valid_o) vcount++; if (do_sqrt_o) dcount++;
        core_valid_i = 1'b1; core_res_i = 8'h00;
        @(negedge clk); core_valid_i = 1'b0;
        if (valid_o) vcount++;
        checks++;
        if ({valid_o, invalid_o, res_o} !== {2'b10, 16'h4080}) begin
            failures++;
            $display("FAIL wrap: got %b/%h expected 10/4080", {valid_o, invalid_o}, res_o);
        end
        repeat (3) begin
            @(negedge clk);
            if (valid_o) vcount++;
            if (do_sqrt_o) dcount++;
        end
        checks++;
        if ({vcount, dcount} !== {32'd1, 32'd1}) begin
            failures++;
            $display("FAIL pulse_count: got valid=%0d do_sqrt=%0d expected 1 and 1", vcount, dcount);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk); start_i = 1'b1; op_i = 16'h4080;
        @(negedge clk); start_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        core_valid_i = 1'b1; core_res_i = 8'h80;
        @(negedge clk); core_valid_i = 1'b0;
        checks++;
        if ({valid_o, busy_o, do_sqrt_o, res_o} !== {3'b000, 16'h0}) begin
            failures++;
            $display("FAIL reset_abort: got %b/%h expected 000/0000", {valid_o, busy_o, do_sqrt_o}, res_o);
        end
        @(negedge clk);
        checks++;
        if ({valid_o, busy_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_abort_late: got %b expected 00", {valid_o, busy_o});
        end
        test_normal(16'h4080, 8'h80, 1'b0, 8'h80, 16'h4000);
    endtask

`ifdef LAMP_SQRT_TIMEOUT_EN
    task automatic test_timeout();
        int early = 0;
        @(negedge clk); start_i = 1'b1; op_i = 16'h4080;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk);
        if (valid_o) early++;
        repeat (63) begin
            @(negedge clk);
            if (valid_o) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL timeout_early: got %0d valid cycles expected 0", early);
        end
        @(negedge clk);
        checks++;
        if ({valid_o, invalid_o, timeout_o, res_o} !== {3'b111, 16'h7FC0}) begin
            failures++;
            $display("FAIL timeout: got %b/%h expected 111/7fc0", {valid_o, invalid_o, timeout_o}, res_o);
        end
        @(negedge clk);
        checks++;
        if ({valid_o, timeout_o, busy_o} !== 3'b000) begin
            failures++;
            $display("FAIL timeout_after: got %b expected 000", {valid_o, timeout_o, busy_o});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_normal(16'h4080, 8'h80, 1'b0, 8'h80, 16'h4000);
        test_normal(16'h4000, 8'h80, 1'b1, 8'hB5, 16'h3FB5);
        test_specials();
        test_wrap_and_ignored_start();
        test_reset_mid_wait();
`ifdef LAMP_SQRT_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lampfpu_sqrt_ctrl.md
Name: lampfpu_sqrt_ctrl

Overview:
- Initiator side of the significand square-root core handshake. It unpacks a 16-bit LAMP float (1 sign, 8 exponent with bias 127, 7 fraction bits) and resolves special operands locally.
- For normal operands it issues the significand and exponent parity to the core, waits for the core's valid pulse, and packs sign, halved exponent and returned significand into the final float.
- Sits between the FPU operation dispatch and the sqrt core.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before a forced abort (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  request; accepted only when busy_o=0
- op_i  in  16  operand {sign, exp[7:0], frac[6:0]}
- busy_o  out  1  high from the cycle after accept until the cycle valid_o is high, inclusive
- valid_o  out  1  one-cycle result pulse
- res_o  out  16  packed result; valid only while valid_o=1
- invalid_o  out  1  invalid-operation flag; qualified by valid_o
- do_sqrt_o  out  1  one-cycle start pulse to the core
- s_o  out  8  significand {1'b1, frac} to the core
- is_exp_odd_o  out  1  unbiased exponent is odd; to the core
- core_valid_i  in  1  core result pulse
- core_res_i  in  8  core result significand, hidden bit at [7]

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers 0. Reset mid-operation aborts to IDLE with no valid_o. The core shares rst.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: on start_i=1, classify op_i and register sign, exponent and fraction.
  - NaN (exp=FF, frac≠0): result 16'h7FC0, invalid 0.
  - +inf: result 16'h7F80.
  - Zero or denormal (exp=00): flush to a signed zero; -0 gives 16'h8000, invalid 0.
  - Negative nonzero: result 16'h7FC0, invalid 1.
  - Any special case goes to DONE. Otherwise go to ISSUE.
- ISSUE (one cycle): do_sqrt_o=1; s_o={1,frac}; is_exp_odd_o=~exp[0]. Then go to WAIT.
- s_o and is_exp_odd_o stay stable from ISSUE until core_valid_i is sampled.
- Result exponent: res_exp = (exp+127)>>1, computed in 9 bits, truncated to 8 bits. This is correct for both parities.
- WAIT: on core_valid_i=1, pack {0, res_exp, core_res_i[6:0]} and go to DONE.
  - If core_res_i[7]=0 (core rounding wrap), pack {0, res_exp+1, 7'b0} instead.
- DONE (one cycle): valid_o=1, res_o and invalid_o driven; the next state is IDLE.
- Latency from accept edge k:
  - Special operand: valid_o high during cycle k+1.
  - Normal operand: do_sqrt_o high during cycle k+1; valid_o high the cycle after core_valid_i is sampled.
- start_i outside IDLE is ignored, not queued.
- core_valid_i outside WAIT is ignored.
- start_i in the same cycle as DONE is ignored; a new start is accepted in IDLE only.
- res_o holds its last value outside valid_o.

Optional Feature:
- Macro: LAMP_SQRT_TIMEOUT_EN.
- Enabled:
  - A cycle counter clears on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without core_valid_i, go to DONE with res_o=16'h7FC0 and invalid_o=1.
  - Extra output port timeout_o (1 bit) pulses with that valid_o.
- Disabled: no counter, no timeout_o port; WAIT holds indefinitely until core_valid_i.

Test Plan:
- op_i=16'h4080 (4.0) → s_o=8'h80, is_exp_odd_o=0, single do_sqrt_o pulse; core answers 8'h80 → res_o=16'h4000, invalid_o=0.
- op_i=16'h4000 (2.0) → is_exp_odd_o=1; core answers 8'hB5 → res_o=16'h3FB5.
- op_i=16'hC080 → valid_o at k+1, res_o=16'h7FC0, invalid_o=1, do_sqrt_o never asserted. Repeat with 16'h8000 → 16'h8000, invalid_o=0; 16'h7F80 → 16'h7F80; 16'h0001 → 16'h0000.
- op_i=16'h4080 with core answering 8'h00 (wrap) → res_o=16'h4080. Extra start_i pulses during WAIT are ignored; exactly one valid_o.
- Assert rst during WAIT, then core_valid_i=1 → no valid_o, busy_o=0; a following start of 16'h4080 completes normally.
- With LAMP_SQRT_TIMEOUT_EN and TIMEOUT_CYCLES=64, core silent → valid_o 64 cycles after entering WAIT, res_o=16'h7FC0, invalid_o=1, timeout_o=1.
